// File: rtl/timing_pkg.sv
// timing_pkg: run-state type, width helper and default sizes shared by the beat timing chain
package timing_pkg;
  typedef enum logic [1:0] {STOPPED, RUNNING, STEPPING} run_state_e;
  localparam int DEF_DIGITS = 32;
  localparam int DEF_BO_DIGITS = 4;
  localparam int DEF_BEATS = 4;
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/beat_run_ctl.sv
// beat_run_ctl: run/step/halt FSM deciding whether the beat counter may advance
module beat_run_ctl
  import timing_pkg::*;
(
  input  logic       dashclk,
  input  logic       nreset,
  input  logic       run,
  input  logic       step,
  input  logic       halt,
  input  logic       tick,
  output run_state_e state,
  output logic       adv
);
  run_state_e state_q, state_d;
  logic step_pend_q, step_pend_d, halt_pend_q, halt_pend_d, halted_q, halted_d;
  logic leave_run, take_step;
  always_ff @(posedge dashclk or negedge nreset)
    if (!nreset) begin
      state_q     <= STOPPED;
      step_pend_q <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
    end
  always_comb begin
    state_d = state_q;
    if (tick)
      state_d = state_q == STOPPED ? ((run && !halted_q) ? RUNNING : step_pend_q ? STEPPING : STOPPED) :
                state_q == RUNNING ? ((!run || halt_pend_q) ? STOPPED : RUNNING) : STOPPED;
    leave_run   = tick && state_q == RUNNING && state_d == STOPPED;
    take_step   = tick && state_q == STOPPED && state_d == STEPPING;
    // a step only counts while stopped; it survives a tick where run wins
    step_pend_d = (step_pend_q || (state_q == STOPPED && step)) && !take_step;
    halt_pend_d = (halt_pend_q && !leave_run) || halt;
    halted_d    = (halted_q || (leave_run && halt_pend_q)) && run;
    state       = state_q;
    adv         = state_q != STOPPED;
  end
endmodule

// File: rtl/beat_timing_gen.sv
// beat_timing_gen: free-running digit/blackout chain with an FSM-gated one-hot beat counter
module beat_timing_gen
  import timing_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int BO_DIGITS = DEF_BO_DIGITS,
  parameter int BEATS     = DEF_BEATS,
  localparam int DW       = cw(DIGITS + BO_DIGITS),
  localparam int BW       = cw(BEATS)
) (
  input  logic              dashclk,
  input  logic              nreset,
  input  logic              run,
  input  logic              step,
  input  logic              halt,
  output logic [DIGITS-1:0] ps,
  output logic [DW-1:0]     digit,
  output logic              bo,
  output logic              nbo,
  output logic [BEATS-1:0]  beat,
  output logic              hs,
  output logic              ha,
  output logic              running,
  output logic              ce
);
  localparam logic [DW-1:0] LAST     = DW'(DIGITS + BO_DIGITS - 1);
  localparam logic [DW-1:0] FIRST_BO = DW'(DIGITS);
  localparam logic [BW-1:0] BLAST    = BW'(BEATS - 1);
  logic [DW-1:0] digit_q, digit_d;
  logic [BW-1:0] b_q, b_d;
  logic last, tick, adv;
  run_state_e state;
  beat_run_ctl u_ctl (
    .dashclk(dashclk),
    .nreset (nreset),
    .run    (run),
    .step   (step),
    .halt   (halt),
    .tick   (tick),
    .state  (state),
    .adv    (adv)
  );
  always_comb begin
    last    = digit_q == LAST;
    tick    = last && (state == STOPPED || b_q == BLAST);
    digit_d = last ? '0 : digit_q + 1'b1;
    b_d     = !(last && adv) ? b_q : (b_q == BLAST) ? '0 : b_q + 1'b1;
  end
  always_ff @(posedge dashclk or negedge nreset)
    if (!nreset) begin
      digit_q <= '0;
      b_q     <= '0;
    end else begin
      digit_q <= digit_d;
      b_q     <= b_d;
    end
  always_comb begin
    digit   = digit_q;
    bo      = digit_q >= FIRST_BO;
    nbo     = !bo;
    ps      = bo ? '0 : DIGITS'(1) << digit_q;
    beat    = BEATS'(1) << b_q;
    hs      = b_q == '0;
    ha      = !hs;
    running = state != STOPPED;
    ce      = last && b_q == BLAST && running;
  end
endmodule

// File: tb/tb_beat_timing_gen.sv
// tb_beat_timing_gen: scoreboard bench for the default and the 20/2/2 beat timing generators
module tb_beat_timing_gen;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic run = 1'b0, step = 1'b0, halt = 1'b0, run2 = 1'b0, flush = 1'b0;
  logic [31:0] ps;
  logic [5:0]  digit;
  logic [3:0]  beat;
  logic        bo, nbo, hs, ha, running, ce;
  logic [19:0] ps2;
  logic [4:0]  digit2;
  logic [1:0]  beat2;
  logic        bo2, nbo2, hs2, ha2, running2, ce2;
  logic        pr = 1'b0, pr2 = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int c; int k; logic [31:0] v;} smp_t;
  typedef struct {int c; int k;} evt_t;
  smp_t sq[$];
  evt_t evq[$];
  string knm [8] = '{"ps", "flags", "beat", "digit", "flags2", "beat2", "digit2", "ps2"};
  string enm [6] = '{"ce", "run_rise", "run_fall", "ce2", "run_rise2", "run_fall2"};
  logic [31:0] rv [8] = '{32'd1, 32'h06, 32'd1, 32'd0, 32'h06, 32'd1, 32'd0, 32'd1};

  always #5 clk = ~clk;

  beat_timing_gen dut (
    .dashclk(clk), .nreset(nreset), .run(run), .step(step), .halt(halt),
    .ps(ps), .digit(digit), .bo(bo), .nbo(nbo), .beat(beat),
    .hs(hs), .ha(ha), .running(running), .ce(ce)
  );
  beat_timing_gen #(.DIGITS(20), .BO_DIGITS(2), .BEATS(2)) dut2 (
    .dashclk(clk), .nreset(nreset), .run(run2), .step(1'b0), .halt(1'b0),
    .ps(ps2), .digit(digit2), .bo(bo2), .nbo(nbo2), .beat(beat2),
    .hs(hs2), .ha(ha2), .running(running2), .ce(ce2)
  );

  // cycle n = digit period after the n-th edge since reset release
  always @(posedge clk or negedge nreset) cyc <= !nreset ? 0 : cyc + 1;

  function automatic logic [31:0] obs(input int k);
    case (k)
      0: return ps;
      1: return {26'd0, running, ce, ha, hs, nbo, bo};
      2: return {28'd0, beat};
      3: return {26'd0, digit};
      4: return {26'd0, running2, ce2, ha2, hs2, nbo2, bo2};
      5: return {30'd0, beat2};
      6: return {27'd0, digit2};
      default: return {12'd0, ps2};
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  task automatic ev(input int k);
    int idx = -1;
    checks++;
    foreach (evq[i]) if (idx < 0 && evq[i].k == k) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s unexpected at cyc=%0d", enm[k], cyc);
    end else begin
      if (evq[idx].c != cyc) begin
        errors++;
        $display("FAIL %s at cyc=%0d exp cyc=%0d", enm[k], cyc, evq[idx].c);
      end
      evq.delete(idx);
    end
  endtask

  task automatic at(input int c, input logic [31:0] p, input logic [5:0] f, input logic [3:0] b, input logic [5:0] d);
    sq.push_back('{c, 0, p});
    sq.push_back('{c, 1, {26'd0, f}});
    sq.push_back('{c, 2, {28'd0, b}});
    sq.push_back('{c, 3, {26'd0, d}});
  endtask

  task automatic at2(input int c, input logic [5:0] f, input logic [1:0] b, input logic [4:0] d);
    sq.push_back('{c, 4, {26'd0, f}});
    sq.push_back('{c, 5, {30'd0, b}});
    sq.push_back('{c, 6, {27'd0, d}});
  endtask

  task automatic ex(input int k, input int c);
    evq.push_back('{c, k});
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #2;
    flush = 1'b0;
  endtask

  initial forever begin
    @(negedge clk or negedge nreset);
    #1;
    if (!nreset) begin
      for (int k = 0; k < 8; k++) cmp({"reset_", knm[k]}, obs(k), rv[k]);
    end else begin
      for (int i = sq.size() - 1; i >= 0; i--)
        if (sq[i].c == cyc) begin
          cmp(knm[sq[i].k], obs(sq[i].k), sq[i].v);
          sq.delete(i);
        end
      if (ce) ev(0);
      if (running && !pr) ev(1);
      if (!running && pr) ev(2);
      if (ce2) ev(3);
      if (running2 && !pr2) ev(4);
      if (!running2 && pr2) ev(5);
      if (flush) begin
        checks++;
        if (sq.size() != 0) begin
          errors++;
          $display("FAIL samples_pending got=%0d exp=0", sq.size());
        end
        checks++;
        if (evq.size() != 0) begin
          errors++;
          $display("FAIL events_missing got=%0d exp=0 first=%s@%0d", evq.size(), enm[evq[0].k], evq[0].c);
        end
      end
    end
    pr = running;
    pr2 = running2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    // flags = {running, ce, ha, hs, nbo, bo}
    at(1, 32'h2, 6'h06, 4'h1, 6'd1);
    at(31, 32'h8000_0000, 6'h06, 4'h1, 6'd31);
    at(32, 32'h0, 6'h05, 4'h1, 6'd32);
    at(35, 32'h0, 6'h05, 4'h1, 6'd35);
    at(36, 32'h1, 6'h26, 4'h1, 6'd0);
    at(71, 32'h0, 6'h25, 4'h1, 6'd35);
    at(72, 32'h1, 6'h2A, 4'h2, 6'd0);
    at(108, 32'h1, 6'h2A, 4'h4, 6'd0);
    at(143, 32'h0, 6'h29, 4'h4, 6'd35);
    at(144, 32'h1, 6'h2A, 4'h8, 6'd0);
    at(179, 32'h0, 6'h39, 4'h8, 6'd35);
    at(180, 32'h1, 6'h26, 4'h1, 6'd0);
    at(300, 32'h1000, 6'h2A, 4'h8, 6'd12);
    at(323, 32'h0, 6'h39, 4'h8, 6'd35);
    at(324, 32'h1, 6'h06, 4'h1, 6'd0);
    at(330, 32'h40, 6'h06, 4'h1, 6'd6);
    at(359, 32'h0, 6'h05, 4'h1, 6'd35);
    at(360, 32'h1, 6'h26, 4'h1, 6'd0);
    at(432, 32'h1, 6'h2A, 4'h4, 6'd0);
    at(503, 32'h0, 6'h39, 4'h8, 6'd35);
    at(504, 32'h1, 6'h06, 4'h1, 6'd0);
    at(620, 32'h100, 6'h06, 4'h1, 6'd8);
    at(700, 32'h10000, 6'h2A, 4'h2, 6'd16);
    at(791, 32'h0, 6'h39, 4'h8, 6'd35);
    at(792, 32'h1, 6'h06, 4'h1, 6'd0);
    at(899, 32'h0, 6'h05, 4'h1, 6'd35);
    at(972, 32'h1, 6'h26, 4'h1, 6'd0);
    at(1115, 32'h0, 6'h39, 4'h8, 6'd35);
    at(1229, 32'h20, 6'h2A, 4'h4, 6'd5);
    at2(19, 6'h06, 2'b01, 5'd19);
    at2(20, 6'h05, 2'b01, 5'd20);
    at2(21, 6'h05, 2'b01, 5'd21);
    at2(22, 6'h06, 2'b01, 5'd0);
    at2(1144, 6'h26, 2'b01, 5'd0);
    at2(1187, 6'h39, 2'b10, 5'd21);
    at2(1229, 6'h2A, 2'b10, 5'd19);
    ex(1, 36);   ex(0, 179);  ex(0, 323);  ex(2, 324);
    ex(1, 360);  ex(0, 503);  ex(2, 504);  ex(1, 648);
    ex(0, 791);  ex(2, 792);  ex(1, 972);  ex(0, 1115);
    ex(2, 1116); ex(4, 1144); ex(1, 1152); ex(3, 1187);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;
    go(10);   run = 1'b1;
    go(260);  run = 1'b0;
    go(340);  step = 1'b1;
    go(341);  step = 1'b0;
    go(400);  step = 1'b1;
    go(401);  step = 1'b0;
    go(620);  run = 1'b1;
    go(700);  halt = 1'b1;
    go(701);  halt = 1'b0;
    go(900);  run = 1'b0;
    go(936);  run = 1'b1;
    go(980);  run = 1'b0;
    go(1120); run = 1'b1;
    go(1130); run2 = 1'b1;
    go(1230);
    do_flush();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b0;
    at(5, 32'h20, 6'h06, 4'h1, 6'd5);
    at(35, 32'h0, 6'h05, 4'h1, 6'd35);
    at(36, 32'h1, 6'h06, 4'h1, 6'd0);
    at2(21, 6'h05, 2'b01, 5'd21);
    at2(22, 6'h26, 2'b01, 5'd0);
    at2(43, 6'h25, 2'b01, 5'd21);
    at2(44, 6'h2A, 2'b10, 5'd0);
    at2(65, 6'h39, 2'b10, 5'd21);
    at2(66, 6'h26, 2'b01, 5'd0);
    at2(160, 6'h06, 2'b01, 5'd6);
    ex(4, 22); ex(3, 65); ex(3, 109); ex(3, 153); ex(5, 154);
    #2 nreset = 1'b1;
    go(120); run2 = 1'b0;
    go(170);
    do_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/beat_timing_gen.md
# beat_timing_gen

Parametrised digit/beat timing generator for the machine clock chain. Free-runs digit pulses and blackout on every `dashclk` period so the store and CRT refresh continues whether or not the machine runs. A run/step/halt control FSM gates the advance of the beat counter, so instructions complete only at whole-cycle boundaries. Generalises the fixed-N pulse chain with configurable digit, blackout and beat counts, binary digit index, one-hot beats and cycle-end signalling.

## Interface
- `DIGITS`, 32, digit pulses per beat (≥2)
- `BO_DIGITS`, 4, blackout digit periods per beat (≥1)
- `BEATS`, 4, beats per instruction cycle (≥2); beat 0 = scan
- `dashclk`  in  1  sole clock; one period = one digit period
- `nreset`  in  1  asynchronous, active-low reset
- `run`  in  1  run/stop switch level
- `step`  in  1  single-shot request; one-cycle pulse
- `halt`  in  1  stop request from execute logic; one-cycle pulse
- `ps`  out  DIGITS  one-hot digit pulse; all zero during blackout
- `digit`  out  DW  current digit-period index, DW = clog2(DIGITS+BO_DIGITS)
- `bo` / `nbo`  out  1  blackout and its complement
- `beat`  out  BEATS  one-hot current beat
- `hs` / `ha`  out  1  scan beat (beat 0) / any action beat
- `running`  out  1  FSM not STOPPED
- `ce`  out  1  cycle end: last digit period of beat BEATS-1 while not STOPPED

## Operation
- L = DIGITS+BO_DIGITS; LAST = L-1. `digit` increments every edge, wraps LAST→0, always, independent of FSM.
- Digit periods 0..DIGITS-1: `ps[digit]`=1, `bo`=0. Periods DIGITS..LAST: `ps`=0, `bo`=1.
- Beat counter b (width max(1,clog2(BEATS))): at edge where digit==LAST and state≠STOPPED, b←(b==BEATS-1)?0:b+1. In STOPPED, b holds 0.
- Boundary tick T: digit==LAST and (state==STOPPED or b==BEATS-1). FSM changes state only on T.
- FSM states STOPPED, RUNNING, STEPPING:
  - STOPPED on T: run & ~halted → RUNNING; else step_pend → STEPPING, clear step_pend.
  - RUNNING on T: ~run or halt_pend → STOPPED; else stay.
  - STEPPING on T: → STOPPED unconditionally.
- `step` is latched into step_pend only while STOPPED; ignored otherwise.
- `halt` sets halt_pend in any state. On the T leaving RUNNING, halt_pend sets `halted` and clears. `halted` clears when run is sampled 0. The operator must cycle run low then high to restart.
- Priority on the same T: halt_pend over run; run over step_pend. step_pend stays pending if run wins.
- All outputs decode registered state only. No combinational path from inputs to outputs.

## Timing
- Reset (async, immediate on `nreset`=0): digit=0, b=0, state STOPPED, step_pend=halt_pend=halted=0.
- Outputs during reset: `ps`=1 (bit 0), `bo`=0, `nbo`=1, `beat`=1, `hs`=1, `ha`=0, `running`=0, `ce`=0.
- First edge after release advances digit to 1.
- Run/step/halt latency: takes effect at the next T. `running` rises in the first digit period after that T.
- Run dropped mid-cycle: the current cycle completes through `ce`, then STOPPED.
- Period: beat = L edges; cycle = BEATS·L edges (defaults 36 / 144).
- `ce` is high for exactly one digit period per completed cycle and coincides with `bo`=1.
- Reset asserted mid-operation: any pending request is discarded.

## Structure
- Shared package `timing_pkg`: run-state enum (STOPPED/RUNNING/STEPPING), width helper for DW and beat width, default constants 32/4/4.
- Sub-module `beat_run_ctl`: FSM plus step_pend/halt_pend/halted. Inputs: `run`, `step`, `halt`, T. Outputs: state and the beat-advance enable.
- Top module: digit counter, beat counter, output decode.

## Test plan
- Defaults, release reset, run=0: `ps[0]` in cycle 0, `ps[31]` in cycle 31, `bo`=1 in cycles 32–35, repeats every 36; `beat`=0001, `hs`=1, `running`=0, `ce` never.
- Run=1 at cycle 10 → `running`=1 from cycle 36. Beats: 0 in cycles 36–71, 1 in 72–107, 2 in 108–143, 3 in 144–179. `ce`=1 in cycle 179 only.
- Running, run→0 during beat 2 → beat 3 completes, `ce` pulses once, then STOPPED with `beat`=0001 held, and digits keep cycling.
- Stopped, `step` pulse, second `step` during STEPPING → exactly one cycle (beats 0–3), one `ce`, back to STOPPED; the second step has no effect.
- run=1, `halt` pulse in beat 1 → stops after that cycle's `ce` and stays stopped with run held 1. Run 0 for one beat, then 1 → RUNNING at the next T.
- `nreset` low mid-beat 2 (DIGITS=20, BO_DIGITS=2, BEATS=2 variant too) → outputs immediately at reset values. After release, period is 22 and `ce` lands at cycle 43 of a run.
